nibble_serial_subtractor: RTL and testbench
===========================================

# nibble_serial_subtractor

Sequential WIDTH-bit subtractor computing D = A − B − Bin one 4-bit nibble per clock, LSB nibble first. Each nibble is resolved by a 4-bit borrow-lookahead stage, and the borrow is registered between nibbles. It is the subtraction counterpart of the team's 4-bit carry-lookahead adder, giving the datapath a small-area, multi-cycle difference unit. Operands enter through a valid/ready request handshake; results leave through a valid/ready response handshake.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, ≥ 4. NIB = WIDTH/4.
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  request valid
- start_ready  out  1  unit idle, can accept
- a  in  WIDTH  minuend, sampled on acceptance
- b  in  WIDTH  subtrahend, sampled on acceptance
- bin  in  1  borrow in, sampled on acceptance
- result_valid  out  1  result available
- result_ready  in  1  consumer takes result
- d  out  WIDTH  difference
- bout  out  1  borrow out of MSB; 1 iff unsigned a < b + bin
- zero  out  1  d == 0
- ovf  out  1  signed overflow: a[MSB] != b[MSB] and d[MSB] != a[MSB]

## Operation
- FSM states: IDLE, RUN, DONE.
- start_ready = (state == IDLE).
- result_valid = (state == DONE).
- IDLE:
  - start_valid && start_ready at an edge is an acceptance.
  - Acceptance latches a and b, loads borrow register = bin, sets nibble index = 0, and moves to RUN.
- RUN:
  - Each edge computes nibble[idx] from a, b and the borrow register.
  - That edge writes d[4*idx+3:4*idx], updates the borrow register and increments idx.
  - The edge that writes nibble NIB−1 also registers bout, zero and ovf, then moves to DONE.
- DONE:
  - d, bout, zero and ovf are held stable while result_ready is low.
  - result_valid && result_ready at an edge is a transfer; the FSM returns to IDLE.
- Per-bit math in the lookahead stage:
  - p_i = ~(a_i ^ b_i), g_i = ~a_i & b_i.
  - br_(i+1) = g_i | (p_i & br_i), d_i = a_i ^ b_i ^ br_i.
  - All four borrows are fully unrolled as two-level logic, not rippled.
- Only one operation is in flight at a time; there is no input buffering.
- While not IDLE, start_valid is ignored and its operands are never captured.
- d and the flags are meaningful only while result_valid is high. Benches must not check them otherwise.

## Timing
- Reset (rst high at an edge): state = IDLE, idx = 0, borrow register = 0, d = 0, bout = 0, zero = 0, ovf = 0.
  - After reset: result_valid = 0, start_ready = 1.
- rst has priority over every handshake. An acceptance or transfer coinciding with rst is discarded.
- Reset mid-RUN or in DONE aborts the operation with no result; the unit is idle on the next cycle.
- Latency: for an acceptance at edge k, result_valid is high in the cycle after edge k+NIB (NIB RUN edges).
- With result_ready held high, an operation occupies NIB+1 cycles (RUN + DONE), then 1 IDLE cycle. Back-to-back throughput is 1 op per NIB+2 cycles.
- After a transfer, start_ready is high in the next cycle. It is never combinationally derived from result_ready.
- Width/wrap rules:
  - d is modulo 2^WIDTH.
  - The borrow chain wraps across nibble boundaries only through the registered borrow.
  - bout = final registered borrow.
- No combinational path from any input to any output except through the state register.

## Structure
- Package nss_pkg holds:
  - the FSM state typedef (enum logic [1:0] {IDLE, RUN, DONE});
  - localparam NIBBLE_W = 4.
- Sub-module borrow_lookahead_4 is purely combinational:
  - inputs a[3:0], b[3:0], bin;
  - outputs d[3:0], bout.
  - It is instantiated once and muxed by idx, so one instance serves all nibbles.
- Top level holds: FSM, idx counter ($clog2(NIB) bits, minimum 1), borrow register, operand registers, result register and flag logic.

## Test plan
1. WIDTH=16, a=0x1234, b=0x0234, bin=0 → d=0x1000, bout=0, zero=0, ovf=0; result_valid exactly 4 cycles after acceptance.
2. a=0x0000, b=0x0001, bin=0 → d=0xFFFF, bout=1, ovf=0; the borrow crosses all 4 nibble boundaries.
3. a=0x8000, b=0x0001, bin=0 → d=0x7FFF, bout=0, ovf=1. Also a=0x5555, b=0x5554, bin=1 → d=0x0000, zero=1, bout=0.
4. Backpressure: hold result_ready=0 for 5 cycles in DONE while start_valid pulses with new operands.
   - Required: d and flags stable, start_ready=0, new operands ignored.
   - Raise result_ready → transfer; start_ready=1 next cycle; the next request is accepted and produces a correct result.
5. Reset mid-RUN after 2 nibbles (a=0xFFFF, b=0x0001) → next cycle result_valid=0, start_ready=1, d=0, flags 0.
   - A following op a=0x0010, b=0x0001 yields d=0x000F, unaffected by the stale borrow.
6. Back-to-back with result_ready tied high: 3 ops accepted as soon as start_ready allows → one result every 6 cycles (NIB+2), in order, all correct versus a reference model.

Source files
------------

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package nss_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_lookahead.sv
// Combinational 4-bit borrow-lookahead subtract stage: d = a - b - bin.
module borrow_lookahead_4
  import nss_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] d,
  output logic                bout
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W:0]   br;

  always_comb begin
    p = ~(a ^ b);
    g = ~a & b;

    // Each borrow is flattened to sum-of-products so no stage waits on another.
    br[0] = bin;
    br[1] = g[0] | (p[0] & bin);
    br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & bin);
    br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);

    d    = a ^ b ^ br[NIBBLE_W-1:0];
    bout = br[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: one nibble per clock, LSB first, borrow
// registered between nibbles, with valid/ready request and response handshakes.
module nibble_serial_subtractor
  import nss_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t state;
  state_t state_next;

  logic [IDX_W-1:0]    idx;
  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    b_reg;
  logic [WIDTH-1:0]    d_reg;
  logic                br;
  logic                bout_reg;
  logic                zero_reg;
  logic                ovf_reg;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] d_nib;
  logic                nib_bout;
  logic [WIDTH-1:0]    d_next;
  logic                last;

  // Select the active nibble and build the full difference as it will look after this edge.
  always_comb begin
    a_nib  = '0;
    b_nib  = '0;
    d_next = d_reg;
    for (int unsigned n = 0; n < NIB; n++) begin
      if (idx == IDX_W'(n)) begin
        a_nib = a_reg[n*NIBBLE_W +: NIBBLE_W];
        b_nib = b_reg[n*NIBBLE_W +: NIBBLE_W];
        d_next[n*NIBBLE_W +: NIBBLE_W] = d_nib;
      end
    end
    last = (idx == IDX_W'(NIB - 1));
  end

  borrow_lookahead_4 u_stage (
    .a    (a_nib),
    .b    (b_nib),
    .bin  (br),
    .d    (d_nib),
    .bout (nib_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_valid)  state_next = RUN;
      RUN:     if (last)         state_next = DONE;
      DONE:    if (result_ready) state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      d_reg    <= '0;
      br       <= 1'b0;
      bout_reg <= 1'b0;
      zero_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_reg <= a;
            b_reg <= b;
            br    <= bin;
            idx   <= '0;
          end
        end
        RUN: begin
          d_reg <= d_next;
          br    <= nib_bout;
          idx   <= idx + 1'b1;
          if (last) begin
            bout_reg <= nib_bout;
            zero_reg <= (d_next == '0);
            ovf_reg  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                        (d_next[WIDTH-1] != a_reg[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);
  assign d            = d_reg;
  assign bout         = bout_reg;
  assign zero         = zero_reg;
  assign ovf          = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed, table-driven bench for nibble_serial_subtractor (WIDTH=16).
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        result_valid;
  logic        result_ready;
  logic [15:0] d;
  logic        bout;
  logic        zero;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .bin          (bin),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .d            (d),
    .bout         (bout),
    .zero         (zero),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                       input string tag);
    int unsigned w = 0;
    while (!start_ready && w < 20) begin
      tick();
      w++;
    end
    chk({tag, " start_ready"}, start_ready, 1);
    a = va;
    b = vb;
    bin = vbin;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic wait_result(output int unsigned lat);
    lat = 0;
    while (!result_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input logic [15:0] ed, input logic eb, input logic ez,
                              input logic eo, input string tag);
    chk({tag, " d"}, d, ed);
    chk({tag, " bout"}, bout, eb);
    chk({tag, " zero"}, zero, ez);
    chk({tag, " ovf"}, ovf, eo);
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int unsigned lat;
    issue(v.a, v.b, v.bin, tag);
    wait_result(lat);
    chk({tag, " latency"}, lat, 4);
    check_result(v.d, v.bout, v.zero, v.ovf, tag);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk({tag, " ready_after_xfer"}, start_ready, 1);
    chk({tag, " valid_after_xfer"}, result_valid, 0);
  endtask

  initial begin
    int unsigned lat;
    vec_t bb[3];
    int unsigned in_idx;
    int unsigned out_idx;
    int unsigned cyc;
    int unsigned last_cyc;
    logic acc;
    logic [16:0] full;

    //         a        b        bin   d        bout  zero  ovf
    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    start_valid = 1'b0;
    result_ready = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset start_ready", start_ready, 1);
    chk("reset result_valid", result_valid, 0);
    check_result(16'h0000, 1'b0, 1'b0, 1'b0, "reset");

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held while new requests are ignored.
    issue(16'h1234, 16'h0234, 1'b0, "bp");
    wait_result(lat);
    chk("bp latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      a = 16'hFFFF;
      b = 16'h0000;
      bin = 1'b1;
      start_valid = (i % 2 == 0);
      check_result(16'h1000, 1'b0, 1'b0, 1'b0, "bp hold");
      chk("bp start_ready", start_ready, 0);
      chk("bp result_valid", result_valid, 1);
      tick();
    end
    start_valid = 1'b0;
    check_result(16'h1000, 1'b0, 1'b0, 1'b0, "bp final");
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("bp ready_after_xfer", start_ready, 1);
    chk("bp valid_after_xfer", result_valid, 0);
    run_op('{16'h0F00, 16'h00FF, 1'b0, 16'h0E01, 1'b0, 1'b0, 1'b0}, "bp next");

    // Reset after two nibbles of a borrow-generating operation.
    issue(16'hFFFF, 16'h0001, 1'b0, "abort");
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort result_valid", result_valid, 0);
    chk("abort start_ready", start_ready, 1);
    check_result(16'h0000, 1'b0, 1'b0, 1'b0, "abort");
    run_op(vecs[4], "after abort");

    // Back-to-back with result_ready held high, checked against a reference model.
    bb[0] = '{16'hABCD, 16'h1234, 1'b0, '0, 1'b0, 1'b0, 1'b0};
    bb[1] = '{16'h1000, 16'h2000, 1'b1, '0, 1'b0, 1'b0, 1'b0};
    bb[2] = '{16'h8001, 16'h8000, 1'b1, '0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      full = {1'b0, bb[i].a} - {1'b0, bb[i].b} - {16'h0000, bb[i].bin};
      bb[i].d    = full[15:0];
      bb[i].bout = full[16];
      bb[i].zero = (full[15:0] == 16'h0000);
      bb[i].ovf  = (bb[i].a[15] != bb[i].b[15]) && (full[15] != bb[i].a[15]);
    end
    result_ready = 1'b1;
    in_idx = 0;
    out_idx = 0;
    cyc = 0;
    last_cyc = 0;
    a = bb[0].a;
    b = bb[0].b;
    bin = bb[0].bin;
    start_valid = 1'b1;
    while (out_idx < 3 && cyc < 100) begin
      if (result_valid) begin
        check_result(bb[out_idx].d, bb[out_idx].bout, bb[out_idx].zero, bb[out_idx].ovf,
                     $sformatf("b2b%0d", out_idx));
        if (out_idx > 0) chk("b2b spacing", cyc - last_cyc, 6);
        last_cyc = cyc;
        out_idx++;
      end
      acc = start_ready && start_valid;
      tick();
      cyc++;
      if (acc) begin
        in_idx++;
        if (in_idx < 3) begin
          a = bb[in_idx].a;
          b = bb[in_idx].b;
          bin = bb[in_idx].bin;
        end else begin
          start_valid = 1'b0;
        end
      end
    end
    chk("b2b results seen", out_idx, 3);
    result_ready = 1'b0;
    start_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
